// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake toward a controlling FSM.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic bit_diff;
  logic bit_borrow;
  assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        res_d  = {bit_diff, res_q[WIDTH-1:1]};
        br_d   = bit_borrow;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // The last bit lands on this same edge, so publish from the next-state values.
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {bit_diff, res_q[WIDTH-1:1]};
          bout_d  = bit_borrow;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, bin8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0]  sb8[$];
  logic [16:0] sb16[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitors: pop the expected result whenever a done pulse appears.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      check("overlap8", 32'(busy8), 32'd0);
      if (sb8.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done8: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        check("result8", 32'({bout8, diff8}), 32'(sb8.pop_front()));
      end
    end
    if (done16 === 1'b1) begin
      check("overlap16", 32'(busy16), 32'd0);
      if (sb16.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done16: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        check("result16", 32'({bout16, diff16}), 32'(sb16.pop_front()));
      end
    end
  end

  task automatic wait_done8(input int acc, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done8 === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      if (busy8 === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [8:0] exp);
    int acc, lat, nb;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    sb8.push_back(exp);
    @(posedge clk); #1;
    acc = cyc;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    wait_done8(acc, lat, nb);
    check("latency8", 32'(lat), 32'd8);
    check("busy_cycles8", 32'(nb), 32'd8);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int acc, lat;
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
    sb16.push_back({1'b0, a} - {1'b0, b} - 17'(bi));
    @(posedge clk); #1;
    acc = cyc;
    start16 = 1'b0;
    a16 = 16'($urandom);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (done16 === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      @(posedge clk); #1;
    end
    check("latency16", 32'(lat), 32'd16);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, lat, nb, t1, ndone;
    logic [7:0] ra, rb;
    logic       rbi;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_res8", 32'({bout8, diff8}), 32'd0);
    check("reset_res16", 32'({bout16, diff16}), 32'd0);

    // Directed vectors with hand-computed {bout, diff}.
    op8(8'h05, 8'h03, 1'b0, 9'h002);
    op8(8'h03, 8'h05, 1'b0, 9'h1FE);
    op8(8'h00, 8'h00, 1'b1, 9'h1FF);
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    op8(8'h80, 8'h01, 1'b0, 9'h07F);

    // start during RUN is ignored and the operands in flight are unaffected.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'h00F);
    @(posedge clk); #1;
    acc = cyc;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(acc, lat, nb);
    check("latency_ignore8", 32'(lat), 32'd8);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) ndone++;
    end
    check("no_second_done8", 32'(ndone), 32'd0);

    // Reset mid-RUN aborts; outputs go back to reset values.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'h022);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start8 = 1'b0;
    sb8.delete();
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_done8", 32'(done8), 32'd0);
    check("abort_res8", 32'({bout8, diff8}), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) ndone++;
    end
    check("abort_no_done8", 32'(ndone), 32'd0);
    op8(8'h10, 8'h01, 1'b0, 9'h00F);

    // Back-to-back with start held high: done pulses 9 cycles apart.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'h002);
    sb8.push_back(9'h1FE);
    @(posedge clk); #1;
    acc = cyc;
    a8 = 8'h03; b8 = 8'h05;
    wait_done8(acc, lat, nb);
    check("latency_b2b_first8", 32'(lat), 32'd8);
    t1 = cyc;
    @(posedge clk); #1;
    acc = cyc;
    start8 = 1'b0;
    wait_done8(acc, lat, nb);
    check("done_spacing8", 32'(cyc - t1), 32'd9);

    // Random operations against the arithmetic reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      op8(ra, rb, rbi, {1'b0, ra} - {1'b0, rb} - 9'(rbi));
    end
    for (int i = 0; i < 1000; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    op16(16'h0000, 16'hFFFF, 1'b1);
    op16(16'hFFFF, 16'h0000, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb16_drained", 32'(sb16.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
